// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI message parser.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [7:0] SYSEX_START     = 8'hF0;
    localparam logic [7:0] SYSEX_END       = 8'hF7;
    localparam logic [7:0] RT_RESET        = 8'hFF;

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational decode of one MIDI byte: status/real-time/system-common class
// and the number of data bytes a channel status byte expects.
module midi_byte_classify (
    input  logic [7:0] byte_in,
    output logic       is_status,
    output logic       is_realtime,
    output logic       is_syscommon,
    output logic [1:0] data_len
);
    import midi_pkg::*;

    assign is_status    = byte_in[7];
    assign is_realtime  = (byte_in[7:3] == 5'b11111);
    assign is_syscommon = (byte_in[7:3] == 5'b11110);

    // Program Change (Cn) and Channel Pressure (Dn) carry a single data byte.
    always_comb begin
        data_len = 2'd0;
        if (byte_in[7] && byte_in[7:4] != 4'hF) begin
            if (byte_in[7:4] == 4'hC || byte_in[7:4] == 4'hD)
                data_len = 2'd1;
            else
                data_len = 2'd2;
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, SysEx skipping, real-time
// pass-through, channel filtering; emits one pulse per completed message.
module midi_msg_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [7:0]  status_out,
    output logic [15:0] data_out,
    output logic        msg_valid,
    output logic        data_en,
    output logic        data_clr
);
    import midi_pkg::*;

    logic       is_status, is_realtime, is_syscommon;
    logic [1:0] data_len;

    midi_byte_classify u_cls (
        .byte_in      (byte_in),
        .is_status    (is_status),
        .is_realtime  (is_realtime),
        .is_syscommon (is_syscommon),
        .data_len     (data_len)
    );

    state_t     state, state_nxt;
    logic [7:0] run_status, run_nxt;
    logic       run_short, short_nxt;
    logic [7:0] data1, d1_nxt;
    logic [7:0] d2;
    logic       done, clr, accept;
    logic [7:0] report_status;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            run_status <= 8'h00;
            run_short  <= 1'b0;
            data1      <= 8'h00;
        end else begin
            state      <= state_nxt;
            run_status <= run_nxt;
            run_short  <= short_nxt;
            data1      <= d1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run_status;
        short_nxt = run_short;
        d1_nxt    = data1;
        d2        = 8'h00;
        done      = 1'b0;
        clr       = 1'b0;
        if (byte_valid) begin
            if (is_realtime) begin
                clr = (byte_in == RT_RESET);
            end else if (byte_in == SYSEX_START) begin
                run_nxt   = 8'h00;
                short_nxt = 1'b0;
                d1_nxt    = 8'h00;
                state_nxt = SYSEX;
            end else if (is_syscommon) begin
                run_nxt   = 8'h00;
                short_nxt = 1'b0;
                d1_nxt    = 8'h00;
                state_nxt = IDLE;
            end else if (is_status) begin
                run_nxt   = byte_in;
                short_nxt = (data_len == 2'd1);
                d1_nxt    = 8'h00;
                state_nxt = WAIT_D1;
            end else begin
                case (state)
                    WAIT_D1: begin
                        d1_nxt = {1'b0, byte_in[6:0]};
                        if (run_short) done = 1'b1;
                        else           state_nxt = WAIT_D2;
                    end
                    WAIT_D2: begin
                        d2        = {1'b0, byte_in[6:0]};
                        done      = 1'b1;
                        state_nxt = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign accept = OMNI || (run_status[3:0] == CHANNEL);

    // Note On with zero velocity is the common Note Off idiom; normalise it.
    always_comb begin
        report_status = run_status;
        if (run_status[7:4] == STATUS_NOTE_ON && d2 == 8'h00)
            report_status = {STATUS_NOTE_OFF, run_status[3:0]};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            status_out <= 8'h00;
            data_out   <= 16'h0000;
            msg_valid  <= 1'b0;
            data_clr   <= 1'b0;
        end else begin
            msg_valid <= done && accept;
            data_clr  <= clr;
            if (done && accept) begin
                status_out <= report_status;
                data_out   <= {d1_nxt, d2};
            end
        end
    end

    assign data_en = msg_valid;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench: a channel-0 filtered instance and an OMNI instance share stimulus.
module tb_midi_msg_parser;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic [7:0]  a_status, o_status;
    logic [15:0] a_data, o_data;
    logic        a_valid, o_valid, a_en, o_en, a_clr, o_clr;

    midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .Clk(Clk), .Rst(Rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .status_out(a_status), .data_out(a_data), .msg_valid(a_valid),
        .data_en(a_en), .data_clr(a_clr)
    );

    midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_omni (
        .Clk(Clk), .Rst(Rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .status_out(o_status), .data_out(o_data), .msg_valid(o_valid),
        .data_en(o_en), .data_clr(o_clr)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int en_bad = 0;
    int clr_cnt = 0;
    logic [7:0]  qs[$], qs_o[$];
    logic [15:0] qd[$], qd_o[$];
    logic [7:0]  stim[$];

    // Record every pulse away from the active edge.
    always @(negedge Clk) begin
        if (a_valid) begin qs.push_back(a_status); qd.push_back(a_data); end
        if (o_valid) begin qs_o.push_back(o_status); qd_o.push_back(o_data); end
        if (a_clr) clr_cnt++;
        if (a_en !== a_valid || o_en !== o_valid) en_bad++;
    end

    task automatic put(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        @(posedge Clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic play();
        qs.delete(); qd.delete(); qs_o.delete(); qd_o.delete();
        foreach (stim[i]) begin
            byte_in = stim[i]; byte_valid = 1'b1;
            @(posedge Clk); #1;
        end
        byte_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (a_status !== 8'h00 || a_data !== 16'h0000 || a_valid !== 1'b0 || a_en !== 1'b0 || a_clr !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got %h/%h v%b e%b c%b want 00/0000 v0 e0 c0", a_status, a_data, a_valid, a_en, a_clr);
        end
    endtask

    task automatic test_note_on_latency();
        put(8'h90); put(8'h3C); put(8'h64);
        checks++;
        if (a_valid !== 1'b1 || a_status !== 8'h90 || a_data !== 16'h3C64) begin
            errors++; $display("FAIL note_on_latency: got v%b %h/%h want v1 90/3C64", a_valid, a_status, a_data);
        end
        @(posedge Clk); #1;
        checks++;
        if (a_valid !== 1'b0 || a_status !== 8'h90 || a_data !== 16'h3C64) begin
            errors++; $display("FAIL note_on_hold: got v%b %h/%h want v0 90/3C64", a_valid, a_status, a_data);
        end
        repeat (2) @(posedge Clk); #1;
    endtask

    task automatic test_running_status();
        stim = '{8'h91, 8'h40, 8'h7F, 8'h42, 8'h10};
        play();
        checks++;
        if (qs_o.size() != 2) begin
            errors++; $display("FAIL running_count: got %0d want 2", qs_o.size());
        end else begin
            checks++;
            if (qs_o[0] !== 8'h91 || qd_o[0] !== 16'h407F || qs_o[1] !== 8'h91 || qd_o[1] !== 16'h4210) begin
                errors++; $display("FAIL running_data: got %h/%h %h/%h want 91/407F 91/4210", qs_o[0], qd_o[0], qs_o[1], qd_o[1]);
            end
        end
        checks++;
        if (qs.size() != 0) begin
            errors++; $display("FAIL filter_ch1: got %0d pulses want 0", qs.size());
        end
    endtask

    task automatic test_realtime();
        stim = '{8'h90, 8'h3C, 8'hF8, 8'h64};
        play();
        checks++;
        if (qs.size() != 1 || qs[0] !== 8'h90 || qd[0] !== 16'h3C64) begin
            errors++; $display("FAIL realtime_interleave: got %0d pulses, first %h/%h want 1 90/3C64", qs.size(), a_status, a_data);
        end
    endtask

    task automatic test_one_byte_msgs();
        stim = '{8'hC0, 8'h05, 8'h07};
        play();
        checks++;
        if (qs.size() != 2) begin
            errors++; $display("FAIL prog_change_count: got %0d want 2", qs.size());
        end else begin
            checks++;
            if (qs[0] !== 8'hC0 || qd[0] !== 16'h0500 || qs[1] !== 8'hC0 || qd[1] !== 16'h0700) begin
                errors++; $display("FAIL prog_change_data: got %h/%h %h/%h want C0/0500 C0/0700", qs[0], qd[0], qs[1], qd[1]);
            end
        end
    endtask

    task automatic test_vel_zero();
        stim = '{8'h90, 8'h3C, 8'h00};
        play();
        checks++;
        if (qs.size() != 1 || a_status !== 8'h80 || a_data !== 16'h3C00) begin
            errors++; $display("FAIL vel_zero: got %0d pulses %h/%h want 1 80/3C00", qs.size(), a_status, a_data);
        end
    endtask

    task automatic test_sysex();
        stim = '{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h3C, 8'h64};
        play();
        checks++;
        if (qs_o.size() != 0 || a_status !== 8'h80 || a_data !== 16'h3C00) begin
            errors++; $display("FAIL sysex_skip: got %0d pulses %h/%h want 0 80/3C00", qs_o.size(), a_status, a_data);
        end
    endtask

    task automatic test_filter();
        stim = '{8'h92, 8'h3C, 8'h64};
        play();
        checks++;
        if (qs.size() != 0 || a_status !== 8'h80 || a_data !== 16'h3C00) begin
            errors++; $display("FAIL filter_ch2: got %0d pulses %h/%h want 0 80/3C00", qs.size(), a_status, a_data);
        end
        checks++;
        if (qs_o.size() != 1 || o_status !== 8'h92 || o_data !== 16'h3C64) begin
            errors++; $display("FAIL omni_ch2: got %0d pulses %h/%h want 1 92/3C64", qs_o.size(), o_status, o_data);
        end
    endtask

    task automatic test_back_to_back();
        // A new status mid-message drops the partial data byte.
        stim = '{8'h90, 8'h3C, 8'h80, 8'h40, 8'h00, 8'h41, 8'h7F};
        play();
        checks++;
        if (qs.size() != 2) begin
            errors++; $display("FAIL restart_count: got %0d want 2", qs.size());
        end else begin
            checks++;
            if (qs[0] !== 8'h80 || qd[0] !== 16'h4000 || qs[1] !== 8'h80 || qd[1] !== 16'h417F) begin
                errors++; $display("FAIL restart_data: got %h/%h %h/%h want 80/4000 80/417F", qs[0], qd[0], qs[1], qd[1]);
            end
        end
    endtask

    task automatic test_reset_mid_msg();
        put(8'h90); put(8'h3C);
        #2 Rst = 1'b1;
        #2;
        checks++;
        if (a_status !== 8'h00 || a_data !== 16'h0000 || a_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got %h/%h v%b want 00/0000 v0", a_status, a_data, a_valid);
        end
        @(negedge Clk); Rst = 1'b0;
        @(posedge Clk); #1;
        qs.delete();
        put(8'h64);
        repeat (2) @(posedge Clk); #1;
        checks++;
        if (qs.size() != 0 || a_status !== 8'h00 || a_data !== 16'h0000) begin
            errors++; $display("FAIL reset_discard: got %0d pulses %h/%h want 0 00/0000", qs.size(), a_status, a_data);
        end
    endtask

    task automatic test_clear();
        clr_cnt = 0;
        put(8'hFF);
        checks++;
        if (a_clr !== 1'b1 || o_clr !== 1'b1) begin
            errors++; $display("FAIL data_clr_pulse: got %b/%b want 1/1", a_clr, o_clr);
        end
        @(posedge Clk); #1;
        checks++;
        if (a_clr !== 1'b0 || clr_cnt != 1) begin
            errors++; $display("FAIL data_clr_width: got clr=%b count=%0d want 0 1", a_clr, clr_cnt);
        end
        // FF must not disturb an in-progress message.
        stim = '{8'h90, 8'h3C, 8'hFF, 8'h64};
        play();
        checks++;
        if (qs.size() != 1 || a_status !== 8'h90 || a_data !== 16'h3C64) begin
            errors++; $display("FAIL rt_reset_transparent: got %0d pulses %h/%h want 1 90/3C64", qs.size(), a_status, a_data);
        end
    endtask

    task automatic test_data_en();
        checks++;
        if (en_bad != 0) begin
            errors++; $display("FAIL data_en_tracks_valid: got %0d divergent cycles want 0", en_bad);
        end
    endtask

    initial begin
        Rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (2) @(posedge Clk); #1;
        test_reset();
        @(negedge Clk); Rst = 1'b0;
        @(posedge Clk); #1;
        test_note_on_latency();
        test_running_status();
        test_realtime();
        test_one_byte_msgs();
        test_vel_zero();
        test_sysex();
        test_filter();
        test_back_to_back();
        test_reset_mid_msg();
        test_clear();
        test_data_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 Parameter CHANNEL, default 4'd0: MIDI channel accepted when OMNI=0.
REQ-002 Parameter OMNI, default 1'b0: 1 = accept all 16 channels.
REQ-003 Clk  input  1  system clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  reset, asynchronous and active-high.
REQ-005 byte_in  input  8  received MIDI byte from the UART receiver.
REQ-006 byte_valid  input  1  one-cycle strobe; byte_in is valid this cycle.
REQ-007 status_out  output  8  status byte of the last completed message.
REQ-008 data_out  output  16  {data1, data2}, i.e. {note, velocity}; data2 = 8'h00 for one-data-byte messages.
REQ-009 msg_valid  output  1  one-cycle pulse; status_out/data_out are valid and new this cycle.
REQ-010 data_en  output  1  equals msg_valid; drives the enable of the downstream 16-bit data register.
REQ-011 data_clr  output  1  one-cycle pulse on System Reset byte 8'hFF; drives the downstream register clear.

Function
REQ-012 States: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX; the encoding is internal.
REQ-013 Bytes are processed only in cycles with byte_valid=1; other cycles hold all state, and msg_valid=data_clr=0.
REQ-014 Real-time byte (8'hF8-8'hFF) in any state: no state, running-status or data change; 8'hFF additionally pulses data_clr the next cycle.
REQ-015 Channel status 8'h80-8'hEF in any state: latch as running status; go to WAIT_D1; discard any partial data.
REQ-016 8'hF0 in any state: clear running status; go to SYSEX.
REQ-017 8'hF1-8'hF7 in any state: clear running status; go to IDLE. 8'hF7 ends SYSEX.
REQ-018 SYSEX: data bytes (MSB=0) are discarded.
REQ-019 IDLE: data bytes are discarded.
REQ-020 WAIT_D1 + data byte: latch data1.
REQ-021 WAIT_D1 continuation: for status high nibble C or D the message is complete and the state stays WAIT_D1; otherwise go to WAIT_D2.
REQ-022 WAIT_D2 + data byte: message complete; return to WAIT_D1 (running status retained).
REQ-023 Message completion: msg_valid pulses exactly one cycle after the completing byte_valid cycle (latency 1).
REQ-024 status_out/data_out update in the same cycle as the msg_valid pulse and hold until the next completion.
REQ-025 Channel filter: a completed message with status[3:0] != CHANNEL and OMNI=0 is dropped: no msg_valid, outputs unchanged, state advances normally.
REQ-026 Velocity-zero rule: Note On (8'h9n) with data2=0 is reported as status 8'h8n (Note Off), data unchanged.
REQ-027 Width rules: data bytes are stored as 7-bit values zero-extended to 8 bits; no arithmetic.
REQ-028 No backpressure: every byte_valid is consumed in its cycle; back-to-back byte_valid in consecutive cycles is supported.

Reset
REQ-029 Rst=1 asynchronously forces IDLE and clears running status and data latches.
REQ-030 Rst=1 forces status_out=8'h00, data_out=16'h0000 and msg_valid=data_en=data_clr=0.
REQ-031 Reset asserted mid-message discards the partial message; the first data byte after release is ignored until a status byte arrives.

Structure
REQ-032 Shared package midi_pkg holds the state typedef and the constants STATUS_NOTE_OFF=4'h8, STATUS_NOTE_ON=4'h9, SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_RESET=8'hFF.
REQ-033 A single sub-module midi_byte_classify (combinational: is_status, is_realtime, is_syscommon, data_len) is instantiated once; all other logic is flat.

Verification
REQ-034 Bytes 90 3C 64, CHANNEL=0 -> one msg_valid, status_out=90, data_out=3C64.
REQ-035 Bytes 91 40 7F 42 10 (running status), OMNI=1 -> two pulses: 91/407F, then 91/4210.
REQ-036 Bytes 90 3C F8 64 (real-time interleaved) -> one pulse, 90/3C64, no state disturbance.
REQ-037 Bytes C0 05 07 -> two pulses: C0/0500, then C0/0700. Bytes 90 3C 00 -> 80/3C00.
REQ-038 Bytes F0 12 34 F7 3C 64 -> no pulse. Bytes 92 3C 64 with CHANNEL=0, OMNI=0 -> no pulse.
REQ-039 Rst pulsed after 90 3C, then 64 -> no pulse and all outputs zero; FF byte -> data_clr pulse one cycle later.
